enc_frame_serializer: RTL and testbench
=======================================

Name: enc_frame_serializer

Overview:
Downstream neighbour of the convolutional encoder. Captures the encoder's 384-bit frame register when the encoder signals completion, then streams it out one code symbol per beat (2 or 3 bits, by code rate) over a valid/ready handshake. The stream feeds the channel model / received-symbol path of the decoder bench.

Parameters:
FRAME_BITS, 384, width of the encoder frame register
SYM_NUM, 128, symbols per frame; 256/2 for rate 1/2 and 384/3 for rate 1/3
SYM_W, 3, output symbol width (MAX_CODE_RATE)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
en_ser  in  1  block enable; when low, state and outputs hold
i_code_rate  in  1  `CODE_RATE_2 or `CODE_RATE_3 encoding from param_def
i_encoder_data  in  FRAME_BITS  encoder frame register, filled MSB-first
i_encoder_done  in  1  level; goes high once the frame is complete and stays high until encoder reset
i_sym_ready  in  1  consumer ready
o_sym  out  SYM_W  current symbol; bit i = generator i output
o_sym_valid  out  1  symbol valid
o_sym_last  out  1  high with the final symbol (index 127)
o_frame_done  out  1  one-cycle pulse after the last symbol transfers
o_busy  out  1  high from capture until frame_done
o_overrun  out  1  sticky; a new done edge arrived while busy

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; symbol counter 0; frame and rate latches 0; done_d 0.
- done edge = i_encoder_done & ~done_d, sampled only when en_ser=1. done_d updates every enabled cycle.
- FSM:
  - IDLE: on a done edge, latch i_encoder_data and i_code_rate, set cnt=0 and o_busy=1, and go to SEND. o_sym_valid rises the next cycle, giving 1-cycle capture latency.
  - SEND: o_sym_valid=1. o_sym and o_sym_last are registered and stable while valid & ~ready. A transfer is valid & ready. On transfer with cnt<127, cnt+1 and the next symbol loads with no bubble. On transfer with cnt=127, go to DONE and drop valid.
  - DONE: for one cycle, o_frame_done=1 and o_busy=0, then return to IDLE.
- Symbol mapping for index k, using the latched frame F:
  - Rate 1/2: o_sym[0]=F[383-2k], o_sym[1]=F[382-2k], o_sym[2]=0.
  - Rate 1/3: o_sym[0]=F[383-3k], o_sym[1]=F[382-3k], o_sym[2]=F[381-3k].
  - Bit indices are computed at full width; the counter is 7 bits and never wraps inside a frame.
- Rate and frame are used only from the latches. Changes on the inputs mid-frame have no effect.
- A done edge in SEND or DONE is ignored and sets o_overrun, which stays set until rst. A done edge in the same cycle as DONE→IDLE is also an overrun; it is not captured.
- i_encoder_done held high across frames does not retrigger; only a new 0→1 edge captures.
- en_ser=0 freezes the FSM, counter and registered outputs. The handshake still completes if ready and valid are both high while en_ser=0? No: transfers are counted only when en_ser=1.
- Reset mid-frame aborts the frame immediately: valid drops asynchronously and no frame_done is issued.

Optional Feature:
SER_ERR_INJECT_EN
- Defined: adds input ports i_err_sym_idx[6:0] and i_err_mask[SYM_W-1:0], latched at capture. Symbol index i_err_sym_idx is output XOR i_err_mask. For rate 1/2, mask bit 2 is forced to 0.
- Undefined: these ports do not exist and symbols are unmodified.

Decomposition:
- param_def package holds FRAME_BITS, SYM_NUM, the `CODE_RATE_2/`CODE_RATE_3 constants, and a typedef enum ser_state_t {SER_IDLE, SER_SEND, SER_DONE}.
- One combinational sub-module, enc_sym_select. Inputs: frame, rate, index. Output: the SYM_W symbol. It is reused later by the decoder's depuncture/bench path.

Test Plan:
- Rate 1/3, F = 384'h800…0 (bit 383 only): symbol 0 = 3'b001, symbols 1-127 = 0, o_sym_last on index 127, frame_done pulses 1 cycle after that transfer.
- Rate 1/2, F[383:128] alternating 1010…, low bits random: every symbol = 3'b001 (F[383-2k]=1, F[382-2k]=0). Low 128 bits never appear.
- Backpressure: i_sym_ready toggles pseudo-randomly, including holding low for 10 cycles. o_sym stays stable while stalled, exactly 128 transfers occur, and there are no duplicates.
- A second done edge at symbol 50: o_overrun=1 and stays set, the current frame completes unchanged, and the frame is not recaptured.
- rst asserted at symbol 60: outputs go to 0 immediately. After release, a fresh done edge streams a full 128 symbols from index 0.
- SER_ERR_INJECT_EN with idx=5, mask=3'b111, rate 1/2, F=0: symbol 5 = 3'b011 and all other symbols are 0.

Source files
------------

// File: rtl/enc_frame_serializer_pkg.sv
// Shared parameters, code-rate encodings and serializer state type.
// Optional build macro used by this block: SER_ERR_INJECT_EN.
`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif

package param_def;
  localparam int FRAME_BITS = 384;
  localparam int SYM_NUM    = 128;
  localparam int SYM_W      = 3;
  localparam int CNT_W      = 7;

  localparam logic CODE_RATE_2 = `CODE_RATE_2;
  localparam logic CODE_RATE_3 = `CODE_RATE_3;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_SEND,
    SER_DONE
  } ser_state_t;
endpackage

// File: rtl/enc_frame_serializer_if.sv
// Symbol stream valid/ready handshake between serializer and its consumer.
interface enc_frame_serializer_if
  import param_def::*;
();
  logic [SYM_W-1:0] sym;
  logic             sym_valid;
  logic             sym_last;
  logic             sym_ready;

  modport master (output sym, sym_valid, sym_last, input sym_ready);
  modport slave  (input sym, sym_valid, sym_last, output sym_ready);
endinterface

// File: rtl/enc_sym_select.sv
// Combinational picker of code symbol idx from an MSB-first encoder frame.
module enc_sym_select
  import param_def::*;
(
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  rate,
  input  logic [CNT_W-1:0]      idx,
  output logic [SYM_W-1:0]      sym
);
  logic [8:0]            shamt;
  logic [FRAME_BITS-1:0] shifted;

  // Shifting the symbol to the top keeps every bit index in range at full width.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    shamt   = {1'b0, idx, 1'b0};
    if (rate == CODE_RATE_3) shamt = shamt + 9'(idx);
    shifted = frame << shamt;
    sym[0]  = shifted[FRAME_BITS-1];
    sym[1]  = shifted[FRAME_BITS-2];
    sym[2]  = (rate == CODE_RATE_3) & shifted[FRAME_BITS-3];
  end
endmodule

// File: rtl/enc_frame_serializer.sv
// Captures the encoder frame on a done edge and streams it one symbol per beat.
// Build macro SER_ERR_INJECT_EN adds a single-symbol error injection port pair.
module enc_frame_serializer
  import param_def::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_ser,
  input  logic                  i_code_rate,
  input  logic [FRAME_BITS-1:0] i_encoder_data,
  input  logic                  i_encoder_done,
`ifdef SER_ERR_INJECT_EN
  input  logic [CNT_W-1:0]      i_err_sym_idx,
  input  logic [SYM_W-1:0]      i_err_mask,
`endif
  enc_frame_serializer_if.master sym_if,
  output logic                  o_frame_done,
  output logic                  o_busy,
  output logic                  o_overrun
);
  ser_state_t            state;
  logic [FRAME_BITS-1:0] frame_q;
  logic                  rate_q;
  logic [CNT_W-1:0]      cnt;
  logic                  done_d;
  logic [SYM_W-1:0]      sym_q;
  logic                  valid_q;
  logic                  last_q;

  logic                  idle;
  logic                  done_edge;
  logic                  xfer;
  logic [FRAME_BITS-1:0] sel_frame;
  logic                  sel_rate;
  logic [CNT_W-1:0]      sel_idx;
  logic [SYM_W-1:0]      sel_sym;
  logic [SYM_W-1:0]      next_sym;

  assign idle      = (state == SER_IDLE);
  assign done_edge = en_ser & i_encoder_done & ~done_d;
  assign xfer      = en_ser & valid_q & sym_if.sym_ready;

  // In IDLE the selector looks at the live inputs so symbol 0 is ready right after capture.
  assign sel_frame = idle ? i_encoder_data : frame_q;
  assign sel_rate  = idle ? i_code_rate : rate_q;
  assign sel_idx   = idle ? '0 : cnt + CNT_W'(1);

  enc_sym_select u_sym_select (
    .frame (sel_frame),
    .rate  (sel_rate),
    .idx   (sel_idx),
    .sym   (sel_sym)
  );

`ifdef SER_ERR_INJECT_EN
  logic [CNT_W-1:0] err_idx_q;
  logic [SYM_W-1:0] err_mask_q;
  logic [CNT_W-1:0] sel_err_idx;
  logic [SYM_W-1:0] sel_err_mask;
  logic [SYM_W-1:0] eff_mask;

  assign sel_err_idx  = idle ? i_err_sym_idx : err_idx_q;
  assign sel_err_mask = idle ? i_err_mask : err_mask_q;
  assign eff_mask     = (sel_rate == CODE_RATE_3) ? sel_err_mask
                                                  : {1'b0, sel_err_mask[SYM_W-2:0]};
  assign next_sym     = (sel_idx == sel_err_idx) ? (sel_sym ^ eff_mask) : sel_sym;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_idx_q  <= '0;
      err_mask_q <= '0;
    end else if (idle && done_edge) begin
      err_idx_q  <= i_err_sym_idx;
      err_mask_q <= i_err_mask;
    end
  end
`else
  assign next_sym = sel_sym;
`endif

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state        <= SER_IDLE;
      frame_q      <= '0;
      rate_q       <= 1'b0;
      cnt          <= '0;
      done_d       <= 1'b0;
      sym_q        <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      o_frame_done <= 1'b0;
      o_busy       <= 1'b0;
      o_overrun    <= 1'b0;
    end else if (en_ser) begin
      done_d       <= i_encoder_done;
      o_frame_done <= 1'b0;
      if (done_edge && !idle) o_overrun <= 1'b1;
      unique case (state)
        SER_IDLE: begin
          if (done_edge) begin
            frame_q <= i_encoder_data;
            rate_q  <= i_code_rate;
            cnt     <= '0;
            sym_q   <= next_sym;
            last_q  <= 1'b0;
            valid_q <= 1'b1;
            o_busy  <= 1'b1;
            state   <= SER_SEND;
          end
        end
        SER_SEND: begin
          if (xfer) begin
            if (cnt == CNT_W'(SYM_NUM - 1)) begin
              valid_q      <= 1'b0;
              last_q       <= 1'b0;
              sym_q        <= '0;
              o_busy       <= 1'b0;
              o_frame_done <= 1'b1;
              state        <= SER_DONE;
            end else begin
              cnt    <= cnt + CNT_W'(1);
              sym_q  <= next_sym;
              last_q <= (cnt == CNT_W'(SYM_NUM - 2));
            end
          end
        end
        SER_DONE: state <= SER_IDLE;
        default:  state <= SER_IDLE;
      endcase
    end
  end

  assign sym_if.sym       = sym_q;
  assign sym_if.sym_valid = valid_q;
  assign sym_if.sym_last  = last_q;
endmodule

// File: tb/tb_enc_frame_serializer.sv
// Directed self-checking bench for enc_frame_serializer (optionally with SER_ERR_INJECT_EN).
module tb_enc_frame_serializer;
  import param_def::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  en_ser;
  logic                  i_code_rate;
  logic [FRAME_BITS-1:0] i_encoder_data;
  logic                  i_encoder_done;
  logic                  o_frame_done;
  logic                  o_busy;
  logic                  o_overrun;
  logic [CNT_W-1:0]      err_idx;
  logic [SYM_W-1:0]      err_mask;

  int n_checks = 0;
  int n_errors = 0;

  enc_frame_serializer_if sym_if ();

  enc_frame_serializer dut (
    .clk            (clk),
    .rst            (rst),
    .en_ser         (en_ser),
    .i_code_rate    (i_code_rate),
    .i_encoder_data (i_encoder_data),
    .i_encoder_done (i_encoder_done),
`ifdef SER_ERR_INJECT_EN
    .i_err_sym_idx  (err_idx),
    .i_err_mask     (err_mask),
`endif
    .sym_if         (sym_if),
    .o_frame_done   (o_frame_done),
    .o_busy         (o_busy),
    .o_overrun      (o_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] exp_sym(input logic [FRAME_BITS-1:0] f, input logic r3, input int k);
    int b;
    logic [2:0] s;
    b    = r3 ? 383 - 3 * k : 383 - 2 * k;
    s[0] = f[b];
    s[1] = f[b-1];
    s[2] = r3 ? f[b-2] : 1'b0;
`ifdef SER_ERR_INJECT_EN
    if (k == int'(err_idx)) s = s ^ (r3 ? err_mask : {1'b0, err_mask[1:0]});
`endif
    return s;
  endfunction

  // mode 0: always ready; mode 1: random ready with a 10-cycle hold-off and an en_ser freeze.
  task automatic run_frame(input logic [FRAME_BITS-1:0] f, input logic r, input int mode,
                           input bit ovr, input int abort_at);
    int k = 0;
    int cycles = 0;
    bit have_held = 0;
    logic [2:0] held = '0;
    logic rdy, en;
    logic r3;
    r3 = (r == CODE_RATE_3);
    i_encoder_data = f;
    i_code_rate    = r;
    i_encoder_done = 1'b1;
    @(negedge clk);
    check("cap_valid", sym_if.sym_valid, 1);
    check("cap_busy", o_busy, 1);
    while (k < SYM_NUM && cycles < 2000) begin
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        check("abort_valid", sym_if.sym_valid, 0);
        check("abort_sym", sym_if.sym, 0);
        check("abort_busy", o_busy, 0);
        i_encoder_done = 1'b0;
        i_sym_ready_drive(1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("abort_no_done", o_frame_done, 0);
          check("abort_idle", sym_if.sym_valid, 0);
        end
        return;
      end
      if (ovr && k == 40) i_encoder_done = 1'b0;
      if (ovr && k == 50) begin
        i_encoder_data = ~f;
        i_code_rate    = ~r;
        i_encoder_done = 1'b1;
      end
      if (have_held) check("stall_hold", sym_if.sym, held);
      check("valid_high", sym_if.sym_valid, 1);
      en  = 1'b1;
      rdy = 1'b1;
      if (mode == 1) begin
        if (cycles >= 20 && cycles < 30) rdy = 1'b0;
        else if (cycles >= 40 && cycles < 45) en = 1'b0;
        else rdy = 1'($urandom_range(0, 1));
      end
      i_sym_ready_drive(rdy);
      en_ser = en;
      if (rdy && en) begin
        check($sformatf("sym_%0d", k), sym_if.sym, exp_sym(f, r3, k));
        check($sformatf("last_%0d", k), sym_if.sym_last, k == SYM_NUM - 1);
        k++;
        have_held = 0;
      end else begin
        held      = sym_if.sym;
        have_held = 1;
      end
      @(negedge clk);
      cycles++;
    end
    en_ser = 1'b1;
    if (k < SYM_NUM) check("timeout_transfers", k, SYM_NUM);
    check("fd_pulse", o_frame_done, 1);
    check("fd_busy", o_busy, 0);
    check("fd_valid", sym_if.sym_valid, 0);
    i_sym_ready_drive(1'b0);
    @(negedge clk);
    check("fd_one_cycle", o_frame_done, 0);
    check("idle_busy", o_busy, 0);
    if (ovr) begin
      check("ovr_set", o_overrun, 1);
      repeat (5) @(negedge clk);
      check("ovr_no_recap_valid", sym_if.sym_valid, 0);
      check("ovr_no_recap_busy", o_busy, 0);
      check("ovr_sticky", o_overrun, 1);
    end
    i_encoder_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic i_sym_ready_drive(input logic v);
    sym_if.sym_ready = v;
  endtask

  initial begin
    logic [FRAME_BITS-1:0] f;
    rst            = 1'b1;
    en_ser         = 1'b1;
    i_code_rate    = CODE_RATE_2;
    i_encoder_data = '0;
    i_encoder_done = 1'b0;
    err_idx        = '0;
    err_mask       = '0;
    sym_if.sym_ready = 1'b0;
    #1;
    check("rst_valid", sym_if.sym_valid, 0);
    check("rst_sym", sym_if.sym, 0);
    check("rst_last", sym_if.sym_last, 0);
    check("rst_fd", o_frame_done, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ovr", o_overrun, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Rate 1/3, only bit 383 set: symbol 0 is 3'b001, the rest zero.
    f = '0;
    f[383] = 1'b1;
    run_frame(f, CODE_RATE_3, 0, 0, -1);

    // Rate 1/2, alternating upper bits: every symbol is 3'b001, low bits never used.
    f[383:128] = {128{2'b10}};
    f[127:0]   = {$urandom, $urandom, $urandom, $urandom};
    run_frame(f, CODE_RATE_2, 0, 0, -1);

    // Backpressure and en_ser freeze, random rate 1/3 frame.
    for (int i = 0; i < 12; i++) f[i*32 +: 32] = $urandom;
    run_frame(f, CODE_RATE_3, 1, 0, -1);
    check("ovr_clear", o_overrun, 0);

    // Second done edge at symbol 50 with changed inputs: overrun, frame unchanged.
    for (int i = 0; i < 12; i++) f[i*32 +: 32] = $urandom;
    run_frame(f, CODE_RATE_2, 0, 1, -1);

    // Reset at symbol 60, then a fresh full frame.
    run_frame(f, CODE_RATE_3, 0, 0, 60);
    check("post_rst_ovr", o_overrun, 0);
    run_frame(f, CODE_RATE_3, 0, 0, -1);

`ifdef SER_ERR_INJECT_EN
    err_idx  = 7'd5;
    err_mask = 3'b111;
    run_frame('0, CODE_RATE_2, 0, 0, -1);
    err_mask = 3'b000;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
